// File: rtl/spi_target_regfile.sv
// SPI mode-0 target that decodes command/address/data frames into a small 8-bit register file.
// All SPI pins are oversampled in the clk_in domain; register 0 is a read-only ID byte.
module spi_target_regfile #(
  parameter int          NUM_REGS = 8,
  parameter logic [7:0]  ID_VALUE = 8'hD1,
  parameter int          SYNC_FF  = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  spi_sck_i,
  input  logic                  spi_csn_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_valid_o,
  output logic [6:0]            wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  frame_active_o
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  logic [SYNC_FF-1:0] sck_sync_reg, csn_sync_reg, mosi_sync_reg;
  logic               sck_prev_reg;
  logic               sck_s, csn_s, mosi_s, sck_rise, sck_fall;

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] addr_reg;
  logic [6:0] shift_reg;
  logic [7:0] shift_in;
  logic [7:0] tx_reg;
  logic       miso_oe_reg;
  logic       wr_valid_reg;
  logic [6:0] wr_addr_reg;
  logic [7:0] wr_data_reg;
  logic [7:0] regs_reg [0:NUM_REGS-1];

  // csn synchronizer resets high so an idle bus never looks like a frame start
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sck_sync_reg  <= '0;
      csn_sync_reg  <= '1;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_FF-2:0], spi_sck_i};
      csn_sync_reg  <= {csn_sync_reg[SYNC_FF-2:0], spi_csn_i};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_FF-2:0], spi_mosi_i};
      sck_prev_reg  <= sck_s;
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_FF-1];
  assign csn_s    = csn_sync_reg[SYNC_FF-1];
  assign mosi_s   = mosi_sync_reg[SYNC_FF-1];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign shift_in = {shift_reg, mosi_s};

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  function automatic logic [7:0] read_byte(input logic [6:0] a);
    if (a == 7'd0)       return ID_VALUE;
    else if (in_range(a)) return regs_reg[a[AW-1:0]];
    else                  return 8'h00;
  endfunction

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      addr_reg     <= '0;
      shift_reg    <= '0;
      tx_reg       <= '0;
      miso_oe_reg  <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      wr_valid_reg <= 1'b0;
      if (csn_s) begin
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        miso_oe_reg <= 1'b0;
        tx_reg      <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= CMD;
            bit_cnt_reg <= '0;
          end
          CMD: if (sck_rise) begin
            shift_reg   <= shift_in[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              addr_reg <= shift_in[6:0];
              if (shift_in[7]) begin
                state_reg   <= RDATA;
                tx_reg      <= read_byte(shift_in[6:0]);
                miso_oe_reg <= 1'b1;
              end else begin
                state_reg <= WDATA;
              end
            end
          end
          WDATA: if (sck_rise) begin
            shift_reg   <= shift_in[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              addr_reg <= addr_reg + 7'd1;
              if (addr_reg != 7'd0 && in_range(addr_reg)) begin
                regs_reg[addr_reg[AW-1:0]] <= shift_in;
                wr_valid_reg <= 1'b1;
                wr_addr_reg  <= addr_reg;
                wr_data_reg  <= shift_in;
              end
            end
          end
          RDATA: begin
            if (sck_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                addr_reg <= addr_reg + 7'd1;
                tx_reg   <= read_byte(addr_reg + 7'd1);
              end
            // the fall right after a byte boundary must keep the freshly loaded MSB
            end else if (sck_fall && bit_cnt_reg != 3'd0) begin
              tx_reg <= {tx_reg[6:0], 1'b0};
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == 0) begin : g_id
        assign regs_o[7:0] = ID_VALUE;
      end else begin : g_rw
        assign regs_o[gi*8 +: 8] = regs_reg[gi];
      end
    end
  endgenerate

  assign spi_miso_o     = miso_oe_reg & tx_reg[7];
  assign spi_miso_oe_o  = miso_oe_reg;
  assign wr_valid_o     = wr_valid_reg;
  assign wr_addr_o      = wr_addr_reg;
  assign wr_data_o      = wr_data_reg;
  assign frame_active_o = ~csn_s;

endmodule

// File: tb/tb_spi_target_regfile.sv
// Randomized frame-level bench for spi_target_regfile against an array-based register model.
module tb_spi_target_regfile;
  localparam int         NUM_REGS = 8;
  localparam logic [7:0] ID_VALUE = 8'hD1;
  localparam int         HALF     = 5;

  logic                  clk_in = 1'b0;
  logic                  reset;
  logic                  spi_sck_i, spi_csn_i, spi_mosi_i;
  logic                  spi_miso_o, spi_miso_oe_o;
  logic [NUM_REGS*8-1:0] regs_o;
  logic                  wr_valid_o;
  logic [6:0]            wr_addr_o;
  logic [7:0]            wr_data_o;
  logic                  frame_active_o;

  spi_target_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE), .SYNC_FF(2)) dut (
    .clk_in(clk_in), .reset(reset), .spi_sck_i(spi_sck_i), .spi_csn_i(spi_csn_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .regs_o(regs_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .frame_active_o(frame_active_o)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int oe_err   = 0;

  logic [7:0]  model [0:NUM_REGS-1];
  logic [14:0] exp_wr[$];
  logic [14:0] obs_wr[$];
  logic [7:0]  data_q[$];
  logic        prev_valid = 1'b0;
  logic        double_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_rd(input int a);
    if (a == 0)        return ID_VALUE;
    if (a < NUM_REGS)  return model[a];
    return 8'h00;
  endfunction

  // Record every committed write as the host-side observer sees it
  always @(posedge clk_in) begin
    #1;
    if (wr_valid_o) begin
      obs_wr.push_back({wr_addr_o, wr_data_o});
      if (prev_valid) double_pulse = 1'b1;
    end
    prev_valid = wr_valid_o;
  end

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic exp_oe,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = tx[7-i];
      repeat (HALF) @(negedge clk_in);
      rx[7-i] = spi_miso_o;
      if (spi_miso_oe_o !== exp_oe) oe_err++;
      spi_sck_i = 1'b1;
      repeat (HALF) @(negedge clk_in);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic compare_state(input string name);
    check($sformatf("%s wr count", name), obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      check($sformatf("%s wr%0d", name, i), obs_wr[i], exp_wr[i]);
    obs_wr.delete();
    exp_wr.delete();
    for (int r = 0; r < NUM_REGS; r++)
      check($sformatf("%s reg%0d", name, r), regs_o[8*r +: 8], model_rd(r));
  endtask

  task automatic frame(input logic is_read, input logic [6:0] addr, input int nbytes,
                       input int last_bits, input string name);
    logic [7:0] rx, d;
    int a, nb;
    oe_err = 0;
    spi_csn_i = 1'b0;
    repeat (6) @(negedge clk_in);
    check($sformatf("%s frame_active", name), frame_active_o, 1'b1);
    spi_byte({is_read, addr}, 8, 1'b0, rx);
    a = addr;
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1 && last_bits > 0) ? last_bits : 8;
      if (is_read) begin
        spi_byte(8'($urandom), 8, 1'b1, rx);
        check($sformatf("%s rd%0d @%0h", name, b, a), rx, model_rd(a));
        a = (a + 1) % 128;
      end else begin
        if (data_q.size() > 0) d = data_q.pop_front();
        else d = 8'($urandom);
        spi_byte(d, nb, 1'b0, rx);
        if (nb == 8) begin
          if (a != 0 && a < NUM_REGS) begin
            model[a] = d;
            exp_wr.push_back({7'(a), d});
          end
          a = (a + 1) % 128;
        end
      end
    end
    repeat (HALF) @(negedge clk_in);
    spi_csn_i = 1'b1;
    repeat (8) @(negedge clk_in);
    check($sformatf("%s oe timing errs", name), oe_err, 0);
    check($sformatf("%s idle oe", name), spi_miso_oe_o, 1'b0);
    check($sformatf("%s idle miso", name), spi_miso_o, 1'b0);
    check($sformatf("%s idle active", name), frame_active_o, 1'b0);
    compare_state(name);
    $display("%s: %s addr=%02h bytes=%0d last_bits=%0d", name, is_read ? "read " : "write",
             addr, nbytes, last_bits);
  endtask

  initial begin
    logic [7:0] rx;
    reset = 1'b0; spi_sck_i = 1'b0; spi_csn_i = 1'b1; spi_mosi_i = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) model[r] = 8'h00;
    repeat (3) @(negedge clk_in);
    check("rst wr_valid", wr_valid_o, 1'b0);
    check("rst miso_oe", spi_miso_oe_o, 1'b0);
    check("rst active", frame_active_o, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    compare_state("rst");

    data_q = '{8'hA5};             frame(1'b0, 7'd3, 1, 0, "t1");
    data_q = '{8'h11, 8'h22, 8'h33}; frame(1'b0, 7'd2, 3, 0, "t2");
    data_q = '{8'h3C};             frame(1'b0, 7'd1, 1, 0, "t3w");
    frame(1'b1, 7'd0, 2, 0, "t3r");
    data_q = '{8'hE7};             frame(1'b0, 7'(NUM_REGS-1), 1, 0, "t4w");
    frame(1'b1, 7'(NUM_REGS-1), 2, 0, "t4r");
    data_q = '{8'h77};             frame(1'b0, 7'd0, 1, 0, "t4id");
    data_q = '{8'hFF};             frame(1'b0, 7'd5, 1, 5, "t5part");
    data_q = '{8'h9E};             frame(1'b0, 7'd5, 1, 0, "t5next");
    frame(1'b1, 7'h7F, 3, 0, "wrap");

    for (int k = 0; k < 24; k++) begin
      logic       rd;
      logic [6:0] ad;
      int         nbyt, lb;
      rd   = 1'($urandom_range(0, 1));
      ad   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                         : 7'($urandom_range(0, NUM_REGS - 1));
      nbyt = $urandom_range(1, 4);
      lb   = (!rd && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      frame(rd, ad, nbyt, lb, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a write data byte
    spi_csn_i = 1'b0;
    repeat (6) @(negedge clk_in);
    spi_byte(8'h01, 8, 1'b0, rx);
    spi_byte(8'h5A, 4, 1'b0, rx);
    reset = 1'b0;
    #3;
    for (int r = 0; r < NUM_REGS; r++) model[r] = 8'h00;
    check("t6 wr_valid", wr_valid_o, 1'b0);
    check("t6 miso", spi_miso_o, 1'b0);
    check("t6 oe", spi_miso_oe_o, 1'b0);
    check("t6 active", frame_active_o, 1'b0);
    check("t6 wr_addr", wr_addr_o, 7'd0);
    spi_sck_i = 1'b0;
    spi_csn_i = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    compare_state("t6rst");
    $display("t6: reset asserted mid write byte");
    data_q = '{8'hC3};             frame(1'b0, 7'd1, 1, 0, "t6post");

    check("no back-to-back wr_valid", double_pulse, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
